sprite_compositor: RTL and testbench

Parametrised multi-sprite layer compositor for the VGA pixel path. Per pixel it works out which sprites cover the current (x, y) position and generates one ROM address per sprite; that address includes the sprite's animation frame. It then colour-keys the returned pixels and overlays the sprites on the background pixel in priority order. It sits between the background ROM and the `vgac` data input. Each sprite reads from a single ROM that holds all of its frames, replacing the one-IP-per-frame scheme, and frame changes are tear-free.

---
 rtl/sprite_pkg.sv | 15 +
 rtl/sprite_compositor_if.sv | 39 +++
 rtl/sprite_anim_seq.sv | 40 ++++
 rtl/sprite_compositor.sv | 139 +++++++++++++
 tb/tb_sprite_compositor.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite compositor pixel path.
package sprite_pkg;

  typedef logic [11:0] pixel_t;

  localparam int unsigned ScreenW     = 640;
  localparam int unsigned ScreenH     = 480;
  localparam pixel_t      DefColorKey = 12'h028;

  function automatic int unsigned spr_addr_w(input int unsigned frames, input int unsigned w,
                                             input int unsigned h);
    return $clog2(frames * w * h);
  endfunction

endpackage

// File: rtl/sprite_compositor_if.sv
// Pixel, sprite-control and ROM signals of the sprite compositor.
interface sprite_compositor_if
  import sprite_pkg::*;
#(
  parameter int unsigned NUM_SPR = 4,
  parameter int unsigned ADDR_W  = 15,
  parameter int unsigned FRAME_W = 3
);

  logic                       pix_valid;
  logic [9:0]                 pix_x;
  logic [8:0]                 pix_y;
  logic                       frame_start;
  logic [NUM_SPR-1:0]         spr_en;
  logic [NUM_SPR*10-1:0]      spr_x;
  logic [NUM_SPR*9-1:0]       spr_y;
  logic [NUM_SPR-1:0]         spr_hold;
  logic [NUM_SPR-1:0]         spr_restart;
  logic [NUM_SPR-1:0]         spr_hflip;
  logic [NUM_SPR*ADDR_W-1:0]  rom_addr;
  logic [NUM_SPR*12-1:0]      rom_data;
  pixel_t                     bg_data;
  pixel_t                     pix_out;
  logic                       out_valid;
  logic [NUM_SPR*FRAME_W-1:0] cur_frame;

  modport master (
    output pix_valid, pix_x, pix_y, frame_start, spr_en, spr_x, spr_y, spr_hold, spr_restart,
           spr_hflip, rom_data, bg_data,
    input  rom_addr, pix_out, out_valid, cur_frame
  );

  modport slave (
    input  pix_valid, pix_x, pix_y, frame_start, spr_en, spr_x, spr_y, spr_hold, spr_restart,
           spr_hflip, rom_data, bg_data,
    output rom_addr, pix_out, out_valid, cur_frame
  );

endinterface

// File: rtl/sprite_anim_seq.sv
// Per-sprite animation frame counter: loop or play-once, restart, commit on frame start.
module sprite_anim_seq #(
  parameter int unsigned FRAMES = 8,
  parameter int unsigned FW     = $clog2(FRAMES)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_en,
  input  logic          i_hold,
  input  logic          i_restart,
  input  logic          i_commit,
  output logic [FW-1:0] o_frame
);

  logic [FW-1:0] r_frame;
  logic [FW-1:0] w_frame_nxt;

  // FRAMES is a power of two, so a plain increment wraps mod FRAMES.
  always_comb begin
    w_frame_nxt = r_frame;
    if (i_restart) begin
      w_frame_nxt = '0;
    end else if (i_commit && i_en) begin
      if (!i_hold || (r_frame != FW'(FRAMES - 1))) begin
        w_frame_nxt = r_frame + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_frame <= '0;
    end else begin
      r_frame <= w_frame_nxt;
    end
  end

  assign o_frame = r_frame;

endmodule

// File: rtl/sprite_compositor.sv
// Multi-sprite hit test, frame-aware ROM addressing, colour keying and priority overlay.
// Optional horizontal mirroring is built only when SPRITE_HFLIP_EN is defined.
module sprite_compositor
  import sprite_pkg::*;
#(
  parameter int unsigned NUM_SPR   = 4,
  parameter int unsigned SPR_W     = 64,
  parameter int unsigned SPR_H     = 48,
  parameter int unsigned FRAMES    = 8,
  parameter int unsigned TICK_DIV  = 6_000_000,
  parameter pixel_t      COLOR_KEY = DefColorKey,
  parameter int unsigned ROM_LAT   = 1
) (
  input logic                clk,
  input logic                rst,
  sprite_compositor_if.slave bus
);

  localparam int unsigned ADDR_W = spr_addr_w(FRAMES, SPR_W, SPR_H);
  localparam int unsigned FW     = $clog2(FRAMES);
  localparam int unsigned DLY    = ROM_LAT + 1;
  localparam int unsigned PW     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [PW-1:0]             r_presc;
  logic                      r_tick_pend;
  logic                      w_tick;
  logic                      w_commit;
  logic [NUM_SPR*FW-1:0]     w_cur_frame;
  logic [NUM_SPR-1:0]        w_hit;
  logic [NUM_SPR*ADDR_W-1:0] w_addr;
  logic [NUM_SPR*ADDR_W-1:0] r_rom_addr;
  logic [NUM_SPR-1:0]        r_hit_sr [DLY];
  logic [DLY-1:0]            r_vld_sr;
  pixel_t                    w_pix;
  pixel_t                    r_pix_out;
  logic                      r_out_valid;

  // A tick wrapping in the same cycle as frame_start is committed immediately.
  assign w_tick   = (r_presc == PW'(TICK_DIV - 1));
  assign w_commit = bus.frame_start & (r_tick_pend | w_tick);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_presc     <= '0;
      r_tick_pend <= 1'b0;
    end else begin
      r_presc <= w_tick ? '0 : r_presc + 1'b1;
      if (bus.frame_start) begin
        r_tick_pend <= 1'b0;
      end else if (w_tick) begin
        r_tick_pend <= 1'b1;
      end
    end
  end

  for (genvar i = 0; i < NUM_SPR; i++) begin : g_spr
    logic [10:0] w_px;
    logic [9:0]  w_py;
    logic [9:0]  w_dx;
    logic [8:0]  w_dy;
    logic [9:0]  w_col;

    sprite_anim_seq #(
      .FRAMES (FRAMES),
      .FW     (FW)
    ) u_seq (
      .clk       (clk),
      .rst       (rst),
      .i_en      (bus.spr_en[i]),
      .i_hold    (bus.spr_hold[i]),
      .i_restart (bus.spr_restart[i]),
      .i_commit  (w_commit),
      .o_frame   (w_cur_frame[i*FW +: FW])
    );

    // Widened compares keep boxes hanging off the screen edge from wrapping to 0.
    assign w_px     = {1'b0, bus.spr_x[i*10 +: 10]};
    assign w_py     = {1'b0, bus.spr_y[i*9 +: 9]};
    assign w_hit[i] = bus.spr_en[i]
                      && ({1'b0, bus.pix_x} >= w_px) && ({1'b0, bus.pix_x} < w_px + 11'(SPR_W))
                      && ({1'b0, bus.pix_y} >= w_py) && ({1'b0, bus.pix_y} < w_py + 10'(SPR_H));
    assign w_dx     = bus.pix_x - bus.spr_x[i*10 +: 10];
    assign w_dy     = bus.pix_y - bus.spr_y[i*9 +: 9];
`ifdef SPRITE_HFLIP_EN
    assign w_col    = bus.spr_hflip[i] ? 10'(SPR_W - 1) - w_dx : w_dx;
`else
    assign w_col    = w_dx;
`endif
    assign w_addr[i*ADDR_W +: ADDR_W] = w_hit[i] ?
        ADDR_W'(w_cur_frame[i*FW +: FW]) * ADDR_W'(SPR_W * SPR_H)
        + ADDR_W'(w_dy) * ADDR_W'(SPR_W) + ADDR_W'(w_col) : '0;
  end

`ifndef SPRITE_HFLIP_EN
  logic w_unused_hflip;
  assign w_unused_hflip = ^bus.spr_hflip;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rom_addr <= '0;
      r_vld_sr   <= '0;
      for (int k = 0; k < DLY; k++) r_hit_sr[k] <= '0;
    end else begin
      r_rom_addr  <= w_addr;
      r_vld_sr[0] <= bus.pix_valid;
      r_hit_sr[0] <= w_hit;
      for (int k = 1; k < DLY; k++) begin
        r_vld_sr[k] <= r_vld_sr[k-1];
        r_hit_sr[k] <= r_hit_sr[k-1];
      end
    end
  end

  always_comb begin
    w_pix = bus.bg_data;
    for (int i = 0; i < NUM_SPR; i++) begin
      if (r_hit_sr[DLY-1][i] && (bus.rom_data[i*12 +: 12] != COLOR_KEY)) begin
        w_pix = bus.rom_data[i*12 +: 12];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pix_out   <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_pix_out   <= w_pix;
      r_out_valid <= r_vld_sr[DLY-1];
    end
  end

  assign bus.rom_addr  = r_rom_addr;
  assign bus.pix_out   = r_pix_out;
  assign bus.out_valid = r_out_valid;
  assign bus.cur_frame = w_cur_frame;

endmodule

// File: tb/tb_sprite_compositor.sv
// Directed bench for sprite_compositor (4 sprites, 64x48, 8 frames, TICK_DIV=4, ROM_LAT=1).
module tb_sprite_compositor;

  localparam int unsigned NS = 4;
  localparam int unsigned AW = 15;
  localparam int unsigned FW = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  sprite_compositor_if #(.NUM_SPR(NS), .ADDR_W(AW), .FRAME_W(FW)) bus ();

  sprite_compositor #(
    .NUM_SPR   (NS),
    .SPR_W     (64),
    .SPR_H     (48),
    .FRAMES    (8),
    .TICK_DIV  (4),
    .COLOR_KEY (12'h028),
    .ROM_LAT   (1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  task automatic clear_inputs;
    bus.pix_valid   = 1'b0;
    bus.pix_x       = '0;
    bus.pix_y       = '0;
    bus.frame_start = 1'b0;
    bus.spr_en      = '0;
    bus.spr_x       = '0;
    bus.spr_y       = '0;
    bus.spr_hold    = '0;
    bus.spr_restart = '0;
    bus.spr_hflip   = '0;
    bus.rom_data    = '0;
    bus.bg_data     = '0;
  endtask

  task automatic set_spr(input int i, input logic [9:0] x, input logic [8:0] y);
    bus.spr_x[i*10 +: 10] = x;
    bus.spr_y[i*9 +: 9]   = y;
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One-cycle pixel; returns rom_addr seen one cycle later and out_valid two cycles later,
  // and leaves the caller just after the edge where the composited pixel lands.
  task automatic send_pixel(input logic [9:0] x, input logic [8:0] y,
                            output logic [NS*AW-1:0] addr, output logic early_vld);
    @(negedge clk);
    bus.pix_x     = x;
    bus.pix_y     = y;
    bus.pix_valid = 1'b1;
    @(posedge clk); #1;
    addr = bus.rom_addr;
    @(negedge clk);
    bus.pix_valid = 1'b0;
    @(posedge clk); #1;
    early_vld = bus.out_valid;
    @(posedge clk); #1;
  endtask

  // Frame-start pulse 9 cycles after the previous one; caller releases frame_start.
  task automatic fire_fs;
    @(negedge clk);
    bus.frame_start = 1'b0;
    repeat (8) @(negedge clk);
    bus.frame_start = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    clear_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_tests++; if (bus.rom_addr !== '0) begin n_fail++; $display("FAIL reset_rom_addr: got %0h want 0", bus.rom_addr); end
    n_tests++; if (bus.pix_out !== 12'h000) begin n_fail++; $display("FAIL reset_pix_out: got %0h want 0", bus.pix_out); end
    n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %0b want 0", bus.out_valid); end
    n_tests++; if (bus.cur_frame !== '0) begin n_fail++; $display("FAIL reset_cur_frame: got %0h want 0", bus.cur_frame); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_hit_addr;
    logic [NS*AW-1:0] a;
    logic ev;
    clear_inputs();
    bus.spr_en = 4'b0001;
    set_spr(0, 10'd100, 9'd50);
    bus.rom_data[11:0] = 12'hABC;
    bus.bg_data = 12'h111;
    send_pixel(10'd110, 9'd52, a, ev);
    n_tests++; if (a[AW-1:0] !== 15'd138) begin n_fail++; $display("FAIL hit_addr: got %0d want 138", a[AW-1:0]); end
    n_tests++; if (ev !== 1'b0) begin n_fail++; $display("FAIL hit_early_valid: got %0b want 0", ev); end
    n_tests++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL hit_out_valid: got %0b want 1", bus.out_valid); end
    n_tests++; if (bus.pix_out !== 12'hABC) begin n_fail++; $display("FAIL hit_pix_out: got %0h want abc", bus.pix_out); end
    @(posedge clk); #1;
    n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL hit_valid_drop: got %0b want 0", bus.out_valid); end
  endtask

  task automatic test_overlap;
    logic [NS*AW-1:0] a;
    logic ev;
    bus.spr_en = 4'b0011;
    set_spr(1, 10'd100, 9'd50);
    bus.rom_data = {12'h000, 12'h000, 12'h028, 12'hF00};
    send_pixel(10'd110, 9'd52, a, ev);
    n_tests++; if (a[2*AW-1:AW] !== 15'd138) begin n_fail++; $display("FAIL ovl_addr1: got %0d want 138", a[2*AW-1:AW]); end
    n_tests++; if (bus.pix_out !== 12'hF00) begin n_fail++; $display("FAIL ovl_keyed_top: got %0h want f00", bus.pix_out); end
    bus.rom_data[23:12] = 12'h0F0;
    send_pixel(10'd110, 9'd52, a, ev);
    n_tests++; if (bus.pix_out !== 12'h0F0) begin n_fail++; $display("FAIL ovl_top_wins: got %0h want 0f0", bus.pix_out); end
    bus.rom_data[11:0]  = 12'h028;
    bus.rom_data[23:12] = 12'h028;
    send_pixel(10'd110, 9'd52, a, ev);
    n_tests++; if (bus.pix_out !== 12'h111) begin n_fail++; $display("FAIL ovl_both_keyed: got %0h want 111", bus.pix_out); end
  endtask

  task automatic test_boundary;
    logic [NS*AW-1:0] a;
    logic ev;
    clear_inputs();
    bus.spr_en = 4'b0001;
    set_spr(0, 10'd100, 9'd50);
    bus.rom_data[11:0] = 12'hF00;
    bus.bg_data = 12'h123;
    send_pixel(10'd163, 9'd50, a, ev);
    n_tests++; if (a[AW-1:0] !== 15'd63) begin n_fail++; $display("FAIL bnd_right_addr: got %0d want 63", a[AW-1:0]); end
    n_tests++; if (bus.pix_out !== 12'hF00) begin n_fail++; $display("FAIL bnd_right_pix: got %0h want f00", bus.pix_out); end
    send_pixel(10'd164, 9'd50, a, ev);
    n_tests++; if (a[AW-1:0] !== 15'd0) begin n_fail++; $display("FAIL bnd_past_right_addr: got %0d want 0", a[AW-1:0]); end
    n_tests++; if (bus.pix_out !== 12'h123) begin n_fail++; $display("FAIL bnd_past_right_pix: got %0h want 123", bus.pix_out); end
    send_pixel(10'd100, 9'd97, a, ev);
    n_tests++; if (a[AW-1:0] !== 15'd3008) begin n_fail++; $display("FAIL bnd_bottom_addr: got %0d want 3008", a[AW-1:0]); end
    send_pixel(10'd100, 9'd98, a, ev);
    n_tests++; if (bus.pix_out !== 12'h123) begin n_fail++; $display("FAIL bnd_past_bottom_pix: got %0h want 123", bus.pix_out); end
    send_pixel(10'd99, 9'd50, a, ev);
    n_tests++; if (bus.pix_out !== 12'h123) begin n_fail++; $display("FAIL bnd_left_pix: got %0h want 123", bus.pix_out); end
    set_spr(0, 10'd600, 9'd0);
    send_pixel(10'd5, 9'd10, a, ev);
    n_tests++; if (a[AW-1:0] !== 15'd0) begin n_fail++; $display("FAIL offscreen_addr: got %0d want 0", a[AW-1:0]); end
    n_tests++; if (bus.pix_out !== 12'h123) begin n_fail++; $display("FAIL offscreen_pix: got %0h want 123", bus.pix_out); end
    bus.spr_en = 4'b0000;
    set_spr(0, 10'd100, 9'd50);
    send_pixel(10'd110, 9'd52, a, ev);
    n_tests++; if (a[AW-1:0] !== 15'd0) begin n_fail++; $display("FAIL disabled_addr: got %0d want 0", a[AW-1:0]); end
  endtask

  task automatic test_hflip;
    logic [NS*AW-1:0] a;
    logic ev;
    logic [AW-1:0] exp_a;
`ifdef SPRITE_HFLIP_EN
    exp_a = 15'd127;
`else
    exp_a = 15'd64;
`endif
    clear_inputs();
    bus.spr_en = 4'b0001;
    set_spr(0, 10'd100, 9'd50);
    bus.spr_hflip = 4'b0001;
    send_pixel(10'd100, 9'd51, a, ev);
    n_tests++; if (a[AW-1:0] !== exp_a) begin n_fail++; $display("FAIL hflip_set_addr: got %0d want %0d", a[AW-1:0], exp_a); end
    bus.spr_hflip = 4'b0000;
    send_pixel(10'd100, 9'd51, a, ev);
    n_tests++; if (a[AW-1:0] !== 15'd64) begin n_fail++; $display("FAIL hflip_clr_addr: got %0d want 64", a[AW-1:0]); end
  endtask

  task automatic test_anim_loop;
    logic [FW-1:0] exp_f;
    clear_inputs();
    do_reset();
    bus.spr_en = 4'b0001;
    for (int k = 1; k <= 8; k++) begin
      repeat (9) @(negedge clk);
      exp_f = FW'(k - 1);
      n_tests++; if (bus.cur_frame[FW-1:0] !== exp_f) begin n_fail++; $display("FAIL loop_hold_between k=%0d: got %0d want %0d", k, bus.cur_frame[FW-1:0], exp_f); end
      bus.frame_start = 1'b1;
      @(posedge clk); #1;
      exp_f = FW'(k % 8);
      n_tests++; if (bus.cur_frame[FW-1:0] !== exp_f) begin n_fail++; $display("FAIL loop_step k=%0d: got %0d want %0d", k, bus.cur_frame[FW-1:0], exp_f); end
      @(negedge clk);
      bus.frame_start = 1'b0;
    end
    n_tests++; if (bus.cur_frame[2*FW-1:FW] !== 3'd0) begin n_fail++; $display("FAIL loop_disabled_keeps: got %0d want 0", bus.cur_frame[2*FW-1:FW]); end
  endtask

  task automatic test_anim_hold;
    logic [FW-1:0] exp_f;
    logic [NS*AW-1:0] a;
    logic ev;
    clear_inputs();
    do_reset();
    bus.spr_en   = 4'b0001;
    bus.spr_hold = 4'b0001;
    set_spr(0, 10'd100, 9'd50);
    for (int k = 1; k <= 10; k++) begin
      fire_fs();
      exp_f = (k > 7) ? 3'd7 : FW'(k);
      n_tests++; if (bus.cur_frame[FW-1:0] !== exp_f) begin n_fail++; $display("FAIL hold_step k=%0d: got %0d want %0d", k, bus.cur_frame[FW-1:0], exp_f); end
    end
    @(negedge clk);
    bus.frame_start = 1'b0;
    send_pixel(10'd110, 9'd52, a, ev);
    n_tests++; if (a[AW-1:0] !== 15'd21642) begin n_fail++; $display("FAIL hold_frame7_addr: got %0d want 21642", a[AW-1:0]); end
  endtask

  task automatic test_restart;
    clear_inputs();
    do_reset();
    bus.spr_en = 4'b0001;
    repeat (3) fire_fs();
    n_tests++; if (bus.cur_frame[FW-1:0] !== 3'd3) begin n_fail++; $display("FAIL rst_pre_frame: got %0d want 3", bus.cur_frame[FW-1:0]); end
    @(negedge clk);
    bus.frame_start = 1'b0;
    bus.spr_restart = 4'b0001;
    @(posedge clk); #1;
    n_tests++; if (bus.cur_frame[FW-1:0] !== 3'd0) begin n_fail++; $display("FAIL restart_alone: got %0d want 0", bus.cur_frame[FW-1:0]); end
    @(negedge clk);
    bus.spr_restart = 4'b0000;
    fire_fs();
    n_tests++; if (bus.cur_frame[FW-1:0] !== 3'd1) begin n_fail++; $display("FAIL restart_then_step: got %0d want 1", bus.cur_frame[FW-1:0]); end
    @(negedge clk);
    bus.frame_start = 1'b0;
    repeat (8) @(negedge clk);
    bus.frame_start = 1'b1;
    bus.spr_restart = 4'b0001;
    @(posedge clk); #1;
    n_tests++; if (bus.cur_frame[FW-1:0] !== 3'd0) begin n_fail++; $display("FAIL restart_vs_commit: got %0d want 0", bus.cur_frame[FW-1:0]); end
    @(negedge clk);
    bus.frame_start = 1'b0;
    bus.spr_restart = 4'b0000;
  endtask

  task automatic test_reset_midline;
    clear_inputs();
    bus.spr_en = 4'b0001;
    set_spr(0, 10'd100, 9'd50);
    bus.rom_data[11:0] = 12'hF00;
    @(negedge clk);
    bus.pix_x     = 10'd110;
    bus.pix_y     = 9'd52;
    bus.pix_valid = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    n_tests++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL midline_pre_valid: got %0b want 1", bus.out_valid); end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL midline_c0: got %0b want 0", bus.out_valid); end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 1; c <= 2; c++) begin
      @(posedge clk); #1;
      n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL midline_c%0d: got %0b want 0", c, bus.out_valid); end
    end
    @(posedge clk); #1;
    n_tests++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL midline_resume: got %0b want 1", bus.out_valid); end
    n_tests++; if (bus.pix_out !== 12'hF00) begin n_fail++; $display("FAIL midline_pix: got %0h want f00", bus.pix_out); end
    @(negedge clk);
    bus.pix_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_hit_addr();
    test_overlap();
    test_boundary();
    test_hflip();
    test_anim_loop();
    test_anim_hold();
    test_restart();
    test_reset_midline();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
